// File: rtl/photon_pulse_emulator.sv
// Synthetic PMT pulse source: LFSR Bernoulli or periodic pulse requests per light phase,
// shaped into fixed-width pulses with a dead time, plus per-phase and drop counters.
module photon_pulse_emulator #(
  parameter int unsigned PULSE_WIDTH = 5,
  parameter int unsigned DEAD_TIME   = 10,
  parameter logic [31:0] LFSR_SEED   = 32'hACE12468
) (
  input  logic        clock_50_mhz,
  input  logic        reset,
  input  logic        enable,
  input  logic        mode,
  input  logic        light_source,
  input  logic [31:0] rate_lit,
  input  logic [31:0] rate_dark,
  output logic        pmt_out,
  output logic [31:0] lit_pulse_count,
  output logic [31:0] dark_pulse_count,
  output logic [31:0] dropped_count
);

  localparam logic [31:0] LfsrTaps  = 32'h80200003;
  localparam logic [31:0] SeedEff   = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [31:0] PulseLoad = 32'(PULSE_WIDTH - 1);
  localparam logic [31:0] DeadLoad  = (DEAD_TIME == 0) ? 32'h0 : 32'(DEAD_TIME - 1);

  typedef enum logic [1:0] {StIdle, StPulse, StDead} state_e;

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] pcnt_q, pcnt_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic        light_q;
  logic        pmt_q, pmt_d;
  logic [31:0] lit_q, lit_d;
  logic [31:0] dark_q, dark_d;
  logic [31:0] drop_q, drop_d;

  logic [31:0] rate;
  logic [31:0] pcnt_eff;
  logic        light_edge;
  logic        req;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
  endfunction

  // Request generation and period counter
  always_comb begin
    rate       = light_source ? rate_lit : rate_dark;
    light_edge = light_source ^ light_q;
    // A phase edge restarts the period as if the counter were already zero this cycle.
    pcnt_eff   = light_edge ? 32'h0 : pcnt_q;
    req        = 1'b0;
    if (enable) begin
      if (mode) begin
        req = (rate != 32'h0) && (pcnt_eff == rate - 32'd1);
      end else begin
        req = lfsr_q < rate;
      end
    end
    pcnt_d = (enable && mode && (rate != 32'h0) && !req) ? pcnt_eff + 32'd1 : 32'h0;
    lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrTaps : 32'h0);
  end

  // Pulse FSM and counters
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    lit_d   = lit_q;
    dark_d  = dark_q;
    drop_d  = drop_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StPulse;
          timer_d = PulseLoad;
          if (light_source) begin
            lit_d = sat_inc(lit_q);
          end else begin
            dark_d = sat_inc(dark_q);
          end
        end
      end
      StPulse: begin
        if (req) begin
          drop_d = sat_inc(drop_q);
        end
        if (timer_q == 32'h0) begin
          if (DEAD_TIME == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StDead;
            timer_d = DeadLoad;
          end
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      StDead: begin
        if (req) begin
          drop_d = sat_inc(drop_q);
        end
        if (timer_q == 32'h0) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    pmt_d = (state_d == StPulse);
  end

  always_ff @(posedge clock_50_mhz) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= 32'h0;
      pcnt_q  <= 32'h0;
      lfsr_q  <= SeedEff;
      light_q <= 1'b0;
      pmt_q   <= 1'b0;
      lit_q   <= 32'h0;
      dark_q  <= 32'h0;
      drop_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pcnt_q  <= pcnt_d;
      lfsr_q  <= lfsr_d;
      light_q <= light_source;
      pmt_q   <= pmt_d;
      lit_q   <= lit_d;
      dark_q  <= dark_d;
      drop_q  <= drop_d;
    end
  end

  assign pmt_out          = pmt_q;
  assign lit_pulse_count  = lit_q;
  assign dark_pulse_count = dark_q;
  assign dropped_count    = drop_q;

endmodule

// File: tb/tb_photon_pulse_emulator.sv
// Bench for photon_pulse_emulator: a cycle model pushes expected pulse-start cycles to a queue,
// a monitor pops them on each pmt_out rising edge; counts and spec timing checked per test.
module tb_photon_pulse_emulator;

  localparam int unsigned PW   = 5;
  localparam int unsigned DT   = 10;
  localparam logic [31:0] SEED = 32'hACE12468;
  localparam logic [31:0] TAPS = 32'h80200003;

  logic        clock_50_mhz = 1'b0;
  logic        reset;
  logic        enable;
  logic        mode;
  logic        light_source;
  logic [31:0] rate_lit;
  logic [31:0] rate_dark;
  logic        pmt_out;
  logic [31:0] lit_pulse_count;
  logic [31:0] dark_pulse_count;
  logic [31:0] dropped_count;

  photon_pulse_emulator #(
    .PULSE_WIDTH(PW),
    .DEAD_TIME  (DT),
    .LFSR_SEED  (SEED)
  ) dut (
    .clock_50_mhz    (clock_50_mhz),
    .reset           (reset),
    .enable          (enable),
    .mode            (mode),
    .light_source    (light_source),
    .rate_lit        (rate_lit),
    .rate_dark       (rate_dark),
    .pmt_out         (pmt_out),
    .lit_pulse_count (lit_pulse_count),
    .dark_pulse_count(dark_pulse_count),
    .dropped_count   (dropped_count)
  );

  always #10 clock_50_mhz = ~clock_50_mhz;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];
  int rise_q[$];

  logic [31:0] m_lfsr, m_pcnt, m_lit, m_dark, m_drop;
  logic        m_light_prev;
  int          m_free_at;

  logic pmt_prev = 1'b0;
  int   hi_len   = 0;
  bit   cut      = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
  endfunction

  // Reference model of the current cycle, evaluated with the inputs about to be clocked in.
  task automatic model_eval();
    logic [31:0] rate, p;
    logic        req;
    if (reset) begin
      if (pmt_out === 1'b1) cut = 1'b1;
      exp_q.delete();
      m_lfsr = SEED; m_pcnt = 0; m_lit = 0; m_dark = 0; m_drop = 0;
      m_light_prev = 1'b0;
      m_free_at = cyc + 1;
    end else begin
      rate = light_source ? rate_lit : rate_dark;
      p    = (light_source != m_light_prev) ? 32'h0 : m_pcnt;
      if (!enable)   req = 1'b0;
      else if (!mode) req = m_lfsr < rate;
      else            req = (rate != 0) && (p == rate - 32'd1);
      m_pcnt = (!enable || !mode || rate == 0 || req) ? 32'h0 : p + 32'd1;
      if (req) begin
        if (cyc >= m_free_at) begin
          exp_q.push_back(cyc + 1);
          m_free_at = cyc + PW + DT + 1;
          if (light_source) m_lit = sat(m_lit);
          else              m_dark = sat(m_dark);
        end else begin
          m_drop = sat(m_drop);
        end
      end
      m_lfsr = {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? TAPS : 32'h0);
      m_light_prev = light_source;
    end
  endtask

  task automatic monitor();
    if (pmt_out && !pmt_prev) begin
      if (exp_q.size() == 0) check("unexpected_rise_cycle", cyc, 0);
      else                   check("rise_cycle", cyc, exp_q.pop_front());
      rise_q.push_back(cyc);
      hi_len = 0;
    end
    if (pmt_out) hi_len++;
    if (!pmt_out && pmt_prev) begin
      if (!cut) check("pulse_width", hi_len, PW);
      cut = 1'b0;
    end
    pmt_prev = pmt_out;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clock_50_mhz);
    cyc++;
    #1;
    monitor();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_rise(input int max);
    int  n0;
    bit  ok;
    n0 = rise_q.size();
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick();
      if (rise_q.size() > n0) ok = 1'b1;
    end
    if (!ok) check("rise_timeout", 0, 1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_lit"}, lit_pulse_count, m_lit);
    check({tag, "_dark"}, dark_pulse_count, m_dark);
    check({tag, "_dropped"}, dropped_count, m_drop);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    tick();
    reset = 1'b0;
    rise_q.delete();
  endtask

  initial begin
    int t0, r, n;
    logic [31:0] snap_lit, snap_drop;
    reset = 1'b1; enable = 1'b0; mode = 1'b1; light_source = 1'b1;
    rate_lit = 0; rate_dark = 0;
    run(3);
    reset = 1'b0;
    check("rst_pmt", 32'(pmt_out), 0);
    check("rst_lit", lit_pulse_count, 0);
    check("rst_dark", dark_pulse_count, 0);
    check("rst_dropped", dropped_count, 0);

    // Reset held 3 cycles mid-pulse, then first mode0 request decided by the seed
    rate_lit = 4; enable = 1'b1;
    wait_rise(20);
    run(1);
    reset = 1'b1;
    tick();
    check("reset_pmt_next_edge", 32'(pmt_out), 0);
    run(2);
    check("reset_mid_lit", lit_pulse_count, 0);
    check("reset_mid_dropped", dropped_count, 0);
    reset = 1'b0; mode = 1'b0; rate_lit = SEED + 32'd1; enable = 1'b1;
    t0 = cyc;
    rise_q.delete();
    tick();
    check("seed_first_req", 32'(pmt_out), 1);
    enable = 1'b0;
    run(30);
    check_counts("t1");

    // Periodic mode, period 100, 1000 cycles
    do_reset();
    mode = 1'b1; light_source = 1'b1; rate_lit = 100; rate_dark = 0; enable = 1'b1;
    t0 = cyc;
    run(1000);
    enable = 1'b0;
    run(20);
    check("t2_num_pulses", rise_q.size(), 10);
    for (int k = 0; k < rise_q.size(); k++) check("t2_start_offset", rise_q[k] - t0, 100 * (k + 1));
    check("t2_lit", lit_pulse_count, 10);
    check("t2_dark", dark_pulse_count, 0);
    check("t2_dropped", dropped_count, 0);
    check_counts("t2");

    // Period 4: requests faster than pulse + dead time
    do_reset();
    rate_lit = 4; enable = 1'b1;
    t0 = cyc;
    run(36);
    enable = 1'b0;
    run(20);
    check("t3_num_pulses", rise_q.size(), 3);
    if (rise_q.size() >= 3) begin
      check("t3_first_start", rise_q[0] - t0, 4);
      check("t3_spacing_a", rise_q[1] - rise_q[0], 16);
      check("t3_spacing_b", rise_q[2] - rise_q[1], 16);
    end
    check("t3_lit", lit_pulse_count, 3);
    check("t3_dropped", dropped_count, 6);
    check_counts("t3");

    // Random mode, p=1/2 lit, 0 dark, phases of 10000 cycles
    do_reset();
    mode = 1'b0; rate_lit = 32'h80000000; rate_dark = 0; enable = 1'b1;
    for (int ph = 0; ph < 4; ph++) begin
      light_source = (ph % 2 == 0);
      run(10000);
    end
    enable = 1'b0; light_source = 1'b1;
    run(20);
    check("t4_dark", dark_pulse_count, 0);
    check("t4_lit_range", 32'(lit_pulse_count > 1000 && lit_pulse_count <= 1334), 1);
    check_counts("t4");

    // Phase edge while pmt_out is high
    do_reset();
    mode = 1'b1; light_source = 1'b1; rate_lit = 20; rate_dark = 7; enable = 1'b1;
    wait_rise(40);
    run(2);
    light_source = 1'b0;
    run(30);
    enable = 1'b0;
    run(20);
    check("t5_num_pulses", rise_q.size(), 2);
    if (rise_q.size() >= 2) check("t5_restart_spacing", rise_q[1] - rise_q[0], 16);
    check("t5_lit", lit_pulse_count, 1);
    check("t5_dark", dark_pulse_count, 1);
    check_counts("t5");

    // Enable dropped mid-pulse
    do_reset();
    light_source = 1'b1; rate_lit = 4; enable = 1'b1;
    wait_rise(20);
    run(1);
    enable = 1'b0;
    snap_lit = lit_pulse_count;
    snap_drop = dropped_count;
    n = rise_q.size();
    run(60);
    check("t6_no_new_rise", rise_q.size(), n);
    check("t6_pmt_low", 32'(pmt_out), 0);
    check("t6_lit_frozen", lit_pulse_count, snap_lit);
    check("t6_drop_frozen", dropped_count, snap_drop);
    check_counts("t6");

    r = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
